fifo_unpack: RTL

FIFO_UNPACK -- requirements
Module: fifo_unpack

---
 rtl/fifo_unpack_pkg.sv | 17 +
 rtl/fifo_unpack_mux.sv | 30 +++
 rtl/fifo_unpack.sv | 94 +++++++++
 3 files changed

// File: rtl/fifo_unpack_pkg.sv
// Shared defaults and helpers for the FIFO word unpacker.
//   DEF_*      : default widths used by fifo_unpack / unpack_mux
//   slice_idx  : maps a beat number onto a slice position of the held word
package fifo_unpack_pkg;

  localparam int unsigned DEF_IN_WIDTH  = 64;
  localparam int unsigned DEF_OUT_WIDTH = 16;
  localparam int unsigned DEF_CNT_BITS  = 2;

  // Beat 0 is the low slice unless the word is sent most-significant first.
  function automatic int unsigned slice_idx(input int unsigned beat,
                                            input int unsigned ratio,
                                            input bit          msb_first);
    return msb_first ? (ratio - 1 - beat) : beat;
  endfunction

endpackage

// File: rtl/fifo_unpack_mux.sv
// Selects one OUT_WIDTH slice of a held word.
//   word_i : held word
//   sel_i  : beat number
//   beat_o : selected slice (beat order set by MSB_FIRST)
module unpack_mux
  import fifo_unpack_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned CNT_BITS  = DEF_CNT_BITS,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic [IN_WIDTH-1:0]  word_i,
  input  logic [CNT_BITS-1:0]  sel_i,
  output logic [OUT_WIDTH-1:0] beat_o
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;

  // One-hot style decode keeps the select index within the word for any CNT_BITS.
  always_comb begin
    beat_o = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (sel_i == CNT_BITS'(i)) begin
        beat_o = word_i[slice_idx(i, RATIO, MSB_FIRST)*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/fifo_unpack.sv
// Pops words from a 1-deep upstream FIFO and emits them as RATIO beats
// over a valid/ready stream.
//   clk, rst        : clock, synchronous active-high reset
//   fifo_empty/dout : upstream FIFO head; fifo_rd pops it
//   flush           : drop the held word
//   out_valid/ready : downstream handshake; out_data beat, out_last final beat
//   busy            : a word is held
module fifo_unpack
  import fifo_unpack_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int unsigned RATIO     = IN_WIDTH / OUT_WIDTH,
  parameter int unsigned CNT_BITS  = DEF_CNT_BITS,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_dout,
  output logic                 fifo_rd,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  logic [IN_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                hold_vld_q,  hold_vld_d;
  logic [CNT_BITS-1:0] beat_cnt_q,  beat_cnt_d;
  logic                accept;

  // Handshake outputs decoded straight from state.
  always_comb begin
    out_valid = hold_vld_q;
    out_last  = hold_vld_q && (beat_cnt_q == CNT_BITS'(RATIO - 1));
    busy      = hold_vld_q;
    accept    = hold_vld_q && out_ready;
    // Pop when idle, or while the final beat leaves, so words stream gap-free.
    fifo_rd   = !rst && !fifo_empty && !flush && (!hold_vld_q || (out_ready && out_last));
  end

  // Next-state: flush beats a pop, a pop beats beat advance.
  always_comb begin
    hold_data_d = hold_data_q;
    hold_vld_d  = hold_vld_q;
    beat_cnt_d  = beat_cnt_q;
    if (flush) begin
      hold_vld_d = 1'b0;
      beat_cnt_d = '0;
    end else if (fifo_rd) begin
      hold_data_d = fifo_dout;
      hold_vld_d  = 1'b1;
      beat_cnt_d  = '0;
    end else if (accept) begin
      if (out_last) begin
        hold_vld_d = 1'b0;
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
      end
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Data holding register; contents are meaningless while hold_vld_q is low.
  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

  unpack_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .CNT_BITS  (CNT_BITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_mux (
    .word_i (hold_data_q),
    .sel_i  (beat_cnt_q),
    .beat_o (out_data)
  );

endmodule
